telemetry_tx: RTL and testbench
===============================

Name: telemetry_tx

Overview:
- Transmit side of the eBike telemetry link. The eBike top instantiates it, and its TX output drives the board TX pin.
- Every telemetry interval it snapshots battery voltage, average motor current and average pedal torque.
- It sends them as a fixed 8-byte frame over an 8N1 UART.
- The frame matches what the bench telemetry monitor (UART_rcv) expects: AA, 55, then three 12-bit values, each sent high byte first.

Parameters:
- BAUD_DIV, 2604: clocks per UART bit (50 MHz / 19200 baud). Legal range 4..4095.
- PERIOD_W, 20: width of the frame-interval counter. A frame is launched every 2^PERIOD_W clocks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- batt_v  in  12  battery voltage from the A2D interface
- avg_curr  in  12  averaged motor current
- avg_torque  in  12  averaged pedal torque
- TX  out  1  UART serial output; idles high
- busy  out  1  high while a frame is being serialized
- frame_done  out  1  one-clock pulse after the final stop bit of a frame

Behaviour:
- Reset (asynchronous, immediate):
  - TX=1, busy=0, frame_done=0.
  - Interval counter, baud counter, bit counter and byte index all cleared; state=IDLE.
  - A frame in progress when reset asserts is abandoned and never resumed.
- Interval counter:
  - Free-runs, PERIOD_W bits, wraps at all-ones.
  - A launch event occurs in each cycle where the count is all-ones. The first launch is therefore 2^PERIOD_W-1 clocks after reset release.
- At a launch with state=IDLE:
  - Register batt_v, avg_curr and avg_torque into 12-bit snapshot registers.
  - Set byte index to 0 and enter START.
  - On the next rising edge TX=0 and busy=1.
- Overrun: a launch while busy=1 is ignored. There is no snapshot and no queueing; the current frame completes untouched.
- Input changes during a frame have no effect; only the snapshot is sent.
- Frame byte order (index 0..7):
  - AA, 55
  - {4'h0,batt[11:8]}, batt[7:0]
  - {4'h0,curr[11:8]}, curr[7:0]
  - {4'h0,torque[11:8]}, torque[7:0]
- Per byte, 8N1: start bit 0, then data LSB first, then stop bit 1. Each bit is held exactly BAUD_DIV clocks. TX is driven from a flop (glitch-free).
- State machine:
  - IDLE: TX=1; go to START on launch.
  - START: hold 0 for BAUD_DIV clocks, then go to DATA with bit count 0.
  - DATA: shift one bit every BAUD_DIV clocks; after bit 7 go to STOP.
  - STOP: hold 1 for BAUD_DIV clocks. Then:
    - if byte index is below 7, increment it and go to START (no idle gap between bytes);
    - if byte index is 7, go to IDLE, drop busy and pulse frame_done for one cycle.
- Frame length is exactly 80*BAUD_DIV clocks from TX falling to busy falling.
- Constraint: 80*BAUD_DIV < 2^PERIOD_W for every interval to produce a frame. If this is violated, alternate launches are dropped per the overrun rule, which is legal and defined behaviour.
- The baud counter is reloaded at every bit boundary, so there is no cumulative drift.
- Byte mux: 12-bit snapshots are zero-extended in the high bytes. Bits 11:8 fill positions 3:0 of the high byte.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n=0 for 5 clocks, release; BAUD_DIV=8, PERIOD_W=12.
  - Required: TX=1, busy=0 during reset and for 4094 clocks after release; first TX fall at clock 4096.
- Frame content:
  - Stimulus: batt_v=12'hABC, avg_curr=12'h123, avg_torque=12'h7F0, bench UART_rcv at BAUD_DIV=8.
  - Required: received bytes AA, 55, 0A, BC, 01, 23, 07, F0 in order; frame_done pulses once; busy high for exactly 640 clocks.
- Snapshot hold:
  - Stimulus: change batt_v from 12'hFFF to 12'h000 one bit-time after a frame starts.
  - Required: bytes 3/4 are 0F/FF; the following frame carries 00/00.
- Bit timing:
  - Stimulus: sample TX at every clock during the first byte.
  - Required: start bit low for exactly 8 clocks; data pattern for AA is 0,1,0,1,0,1,0,1 (LSB first); stop bit high 8 clocks; next start bit begins on the very next clock.
- Overrun:
  - Stimulus: PERIOD_W=9 (512) with BAUD_DIV=8 (640-clock frame).
  - Required: launch at 511 starts a frame; launch at 1023 is ignored; next frame starts at 1535; no frame corruption.
- Mid-frame reset:
  - Stimulus: assert rst_n=0 during byte 4.
  - Required: TX=1 and busy=0 asynchronously in the same cycle; no frame_done; after release the next frame is a complete AA 55 … frame at 2^PERIOD_W-1 clocks.

Source files
------------

// File: rtl/telemetry_tx.sv
// eBike telemetry transmitter: every 2^PERIOD_W clocks, snapshot three 12-bit
// readings and send an 8-byte AA 55 frame over an 8N1 UART.
module telemetry_tx #(
  parameter int BAUD_DIV = 2604,
  parameter int PERIOD_W = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt_v,
  input  logic [11:0] avg_curr,
  input  logic [11:0] avg_torque,
  output logic        TX,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_n;
  logic [PERIOD_W-1:0]   period_cnt;
  logic [11:0]           baud_cnt, baud_n;
  logic [2:0]            bit_cnt, bit_n;
  logic [2:0]            byte_idx, byte_n;
  logic [7:0]            shift, shift_n;
  logic [11:0]           snap_batt, snap_batt_n;
  logic [11:0]           snap_curr, snap_curr_n;
  logic [11:0]           snap_torque, snap_torque_n;
  logic                  tx_q, tx_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  launch;
  logic                  bit_end;
  logic [7:0]            cur_byte;

  assign launch     = &period_cnt;
  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign TX         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) period_cnt <= '0;
    else        period_cnt <= period_cnt + 1'b1;
  end

  // High bytes carry the top nibble of each reading, zero-extended.
  always_comb begin
    cur_byte = 8'hAA;
    case (byte_idx)
      3'd0: cur_byte = 8'hAA;
      3'd1: cur_byte = 8'h55;
      3'd2: cur_byte = {4'h0, snap_batt[11:8]};
      3'd3: cur_byte = snap_batt[7:0];
      3'd4: cur_byte = {4'h0, snap_curr[11:8]};
      3'd5: cur_byte = snap_curr[7:0];
      3'd6: cur_byte = {4'h0, snap_torque[11:8]};
      3'd7: cur_byte = snap_torque[7:0];
      default: cur_byte = 8'hAA;
    endcase
  end

  always_comb begin
    state_n       = state;
    baud_n        = baud_cnt;
    bit_n         = bit_cnt;
    byte_n        = byte_idx;
    shift_n       = shift;
    tx_n          = tx_q;
    busy_n        = busy_q;
    done_n        = 1'b0;
    snap_batt_n   = snap_batt;
    snap_curr_n   = snap_curr;
    snap_torque_n = snap_torque;
    if (state != IDLE) baud_n = bit_end ? 12'd0 : baud_cnt + 12'd1;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (launch) begin
          snap_batt_n   = batt_v;
          snap_curr_n   = avg_curr;
          snap_torque_n = avg_torque;
          byte_n        = 3'd0;
          baud_n        = 12'd0;
          state_n       = START;
          tx_n          = 1'b0;
          busy_n        = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = 3'd0;
          shift_n = cur_byte;
          tx_n    = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
          end
        end
      end
      STOP: begin
        // Back-to-back bytes: the next start bit follows the stop bit directly.
        if (bit_end) begin
          if (byte_idx != 3'd7) begin
            byte_n  = byte_idx + 3'd1;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      byte_idx    <= '0;
      shift       <= '0;
      snap_batt   <= '0;
      snap_curr   <= '0;
      snap_torque <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_n;
      baud_cnt    <= baud_n;
      bit_cnt     <= bit_n;
      byte_idx    <= byte_n;
      shift       <= shift_n;
      snap_batt   <= snap_batt_n;
      snap_curr   <= snap_curr_n;
      snap_torque <= snap_torque_n;
      tx_q        <= tx_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
    end
  end

endmodule

// File: tb/tb_telemetry_tx.sv
// Bench for telemetry_tx: two instances (normal interval and overrun interval)
// checked every cycle against a frame-timing model, plus a UART receiver.
module tb_telemetry_tx;

  localparam int B = 8;
  localparam logic [80:0] BIT_LIT =
    {1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] batt = 12'hABC;
  logic [11:0] curr = 12'h123;
  logic [11:0] torq = 12'h7F0;
  logic [1:0]  txV, busyV, doneV;

  telemetry_tx #(.BAUD_DIV(B), .PERIOD_W(12)) dutA (
    .clk(clk), .rst_n(rst_n), .batt_v(batt), .avg_curr(curr), .avg_torque(torq),
    .TX(txV[0]), .busy(busyV[0]), .frame_done(doneV[0])
  );

  telemetry_tx #(.BAUD_DIV(B), .PERIOD_W(9)) dutB (
    .clk(clk), .rst_n(rst_n), .batt_v(batt), .avg_curr(curr), .avg_torque(torq),
    .TX(txV[1]), .busy(busyV[1]), .frame_done(doneV[1])
  );

  always #5 clk = ~clk;

  int          nChecks = 0;
  int          nFails  = 0;
  int          k       = 0;
  bit          phase2  = 0;
  int          mPer[2] = '{4096, 512};
  string       nm[2]   = '{"A", "B"};
  bit          act[2];
  int          fst[2];
  logic [11:0] snapB[2], snapC[2], snapT[2];
  int          doneCnt[2];
  int          busyRiseB[$];
  logic        prevBusyB = 1'b0;
  int          firstFallA = -1;
  int          busyCntA = 0;
  logic [80:0] capt;
  bit          rxBusy = 0;
  int          rxD;
  logic [7:0]  rxSh;
  logic [7:0]  rxQ[$];
  logic [7:0]  frame1Lit[8] = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h07, 8'hF0};

  task automatic compare(input string name, input logic [95:0] got, input logic [95:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (k=%0d)", name, got, want, k);
    end
  endtask

  function automatic logic [7:0] frameByte(input int i, input int n);
    case (n)
      0: return 8'hAA;
      1: return 8'h55;
      2: return {4'h0, snapB[i][11:8]};
      3: return snapB[i][7:0];
      4: return {4'h0, snapC[i][11:8]};
      5: return snapC[i][7:0];
      6: return {4'h0, snapT[i][11:8]};
      default: return snapT[i][7:0];
    endcase
  endfunction

  // Line level d clocks after the frame's first start-bit edge.
  function automatic logic expTx(input int i, input int d);
    int bitN;
    int pos;
    logic [7:0] v;
    bitN = d / B;
    pos  = bitN % 10;
    v    = frameByte(i, bitN / 10);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return v[pos-1];
  endfunction

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      logic eDone;
      logic eTx;
      eDone = 1'b0;
      if (rst_n) begin
        if (act[i] && (k - fst[i] == 80*B)) begin
          act[i] = 0;
          eDone  = 1'b1;
        end else if (!act[i] && (k % mPer[i] == 0)) begin
          act[i]   = 1;
          fst[i]   = k;
          snapB[i] = batt;
          snapC[i] = curr;
          snapT[i] = torq;
        end
      end
      eTx = act[i] ? expTx(i, k - fst[i]) : 1'b1;
      compare({"tx", nm[i]}, 96'(txV[i]), 96'(eTx));
      compare({"busy", nm[i]}, 96'(busyV[i]), 96'(act[i]));
      compare({"done", nm[i]}, 96'(doneV[i]), 96'(eDone));
      if (rst_n && doneV[i]) doneCnt[i]++;
    end
    if (!rst_n) begin
      rxBusy = 0;
    end else begin
      if (!phase2) begin
        if (k >= 4096 && k <= 4176) capt[k-4096] = txV[0];
        if (k == 4176) compare("bit_timing_byte0", 96'(capt), 96'(BIT_LIT));
        if (firstFallA < 0 && txV[0] == 1'b0) firstFallA = k;
        if (k < 5000 && busyV[0]) busyCntA++;
        if (k == 5000) begin
          compare("first_fall_A", 96'(firstFallA), 96'(4096));
          compare("busy_len_A", 96'(busyCntA), 96'(640));
        end
        if (busyV[1] && !prevBusyB) busyRiseB.push_back(k);
        prevBusyB = busyV[1];
      end
      if (!rxBusy) begin
        if (txV[0] == 1'b0) begin
          rxBusy = 1;
          rxD    = 0;
        end
      end else begin
        rxD++;
        if (rxD >= B + B/2 && ((rxD - B/2) % B == 0)) begin
          int idx;
          idx = (rxD - B/2) / B - 1;
          if (idx < 8) rxSh[idx] = txV[0];
          else begin
            compare("rx_stop", 96'(txV[0]), 96'(1));
            rxQ.push_back(rxSh);
            rxBusy = 0;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus();
    if (!phase2 && k < 4096) return;
    if ($urandom_range(3) == 0) curr = 12'($urandom);
    if ($urandom_range(3) == 0) torq = 12'($urandom);
    if (!phase2 && k < 12288) begin
      if (k == 5000) batt = 12'hFFF;
      if (k == 8200) batt = 12'h000;
    end else if ($urandom_range(3) == 0) begin
      batt = 12'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput();
    end
    rst_n = 1'b1;
    while (k < 16384 + 350) begin
      @(negedge clk);
      k++;
      checkOutput();
      applyStimulus();
    end
    compare("busy_before_abort", 96'(busyV[0]), 96'(1));
    compare("rx_bytes_before_reset", 96'(rxQ.size()), 96'(28));
    rst_n = 1'b0;
    #1;
    compare("async_tx_A", 96'(txV[0]), 96'(1));
    compare("async_busy_A", 96'(busyV[0]), 96'(0));
    act[0] = 0;
    act[1] = 0;
    k      = 0;
    phase2 = 1;
    repeat (5) begin
      @(negedge clk);
      checkOutput();
    end
    rst_n = 1'b1;
    while (k < 4096 + 700) begin
      @(negedge clk);
      k++;
      checkOutput();
      applyStimulus();
    end
    compare("rx_total", 96'(rxQ.size()), 96'(36));
    if (rxQ.size() >= 36) begin
      for (int n = 0; n < 8; n++) compare($sformatf("frame1_byte%0d", n), 96'(rxQ[n]), 96'(frame1Lit[n]));
      compare("snap_hold_hi", 96'(rxQ[10]), 96'(8'h0F));
      compare("snap_hold_lo", 96'(rxQ[11]), 96'(8'hFF));
      compare("snap_next_hi", 96'(rxQ[18]), 96'(8'h00));
      compare("snap_next_lo", 96'(rxQ[19]), 96'(8'h00));
      compare("post_reset_sync0", 96'(rxQ[28]), 96'(8'hAA));
      compare("post_reset_sync1", 96'(rxQ[29]), 96'(8'h55));
    end
    compare("done_count_A", 96'(doneCnt[0]), 96'(4));
    compare("done_count_B", 96'(doneCnt[1]), 96'(20));
    compare("overrun_frames_B", 96'(busyRiseB.size()), 96'(16));
    if (busyRiseB.size() >= 2) begin
      compare("overrun_first_B", 96'(busyRiseB[0]), 96'(512));
      compare("overrun_second_B", 96'(busyRiseB[1]), 96'(1536));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
